// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// memory access encoding and dcache-wait FSM states.
package pipeline_hazard_ctrl_pkg;

  localparam logic [2:0] MEM_NONE     = 3'b000;
  localparam int         MEM_LOAD_BIT = 2;

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear
// and synchronous active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at all-ones; clear wins over inc.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble controller for the dual-issue pipeline
// with dcache-wait FSM and saturating statistics counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ID_valid_a,
  input  logic             ID_valid_b,
  input  logic [4:0]       ID_rj_a,
  input  logic [4:0]       ID_rk_a,
  input  logic [4:0]       ID_rj_b,
  input  logic [4:0]       ID_rk_b,
  input  logic             EX_rf_we_a,
  input  logic             EX_rf_we_b,
  input  logic [4:0]       EX_rf_waddr_a,
  input  logic [4:0]       EX_rf_waddr_b,
  input  logic [2:0]       EX_mem_type_a,
  input  logic [2:0]       EX_mem_type_b,
  input  logic             EX_br_a,
  input  logic             EX_br_b,
  input  logic [2:0]       MEM_mem_type_a,
  input  logic [2:0]       MEM_mem_type_b,
  input  logic             dcache_ready,
  input  logic             cnt_clr,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_dcache,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             bubble_EX,
  output logic             dcache_wait,
  output logic [CNT_W-1:0] cnt_dc_miss,
  output logic [CNT_W-1:0] cnt_dc_stall,
  output logic [CNT_W-1:0] cnt_lu_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  hz_state_t state;

  logic mem_busy;
  logic ld_a, ld_b;
  logic use_a, use_b;
  logic lu_hit;
  logic br;
  logic take_br;
  logic take_lu;
  logic miss;

  // Does any valid ID source read register w?
  function automatic logic id_reads(
    input logic [4:0] w,
    input logic       va,
    input logic [4:0] rja,
    input logic [4:0] rka,
    input logic       vb,
    input logic [4:0] rjb,
    input logic [4:0] rkb
  );
    return (va && ((rja == w) || (rka == w)))
        || (vb && ((rjb == w) || (rkb == w)));
  endfunction

  // Hazard detection terms; r0 destinations never hazard.
  always_comb begin
    mem_busy = ((MEM_mem_type_a != MEM_NONE)
             || (MEM_mem_type_b != MEM_NONE))
             && !dcache_ready;
    ld_a = EX_rf_we_a
        && EX_mem_type_a[MEM_LOAD_BIT]
        && (EX_rf_waddr_a != 5'd0);
    ld_b = EX_rf_we_b
        && EX_mem_type_b[MEM_LOAD_BIT]
        && (EX_rf_waddr_b != 5'd0);
    use_a = id_reads(EX_rf_waddr_a,
                     ID_valid_a, ID_rj_a, ID_rk_a,
                     ID_valid_b, ID_rj_b, ID_rk_b);
    use_b = id_reads(EX_rf_waddr_b,
                     ID_valid_a, ID_rj_a, ID_rk_a,
                     ID_valid_b, ID_rj_b, ID_rk_b);
    lu_hit  = (ld_a && use_a) || (ld_b && use_b);
    br      = EX_br_a || EX_br_b;
    take_br = br && !mem_busy;
    take_lu = lu_hit && !mem_busy && !br;
    miss    = (state == RUN) && mem_busy;
  end

  // Priority arbitration: dcache, then branch, then load-use.
  always_comb begin
    stall_IF     = 1'b0;
    stall_ID     = 1'b0;
    stall_EX     = 1'b0;
    stall_dcache = 1'b0;
    flush_ID     = 1'b0;
    flush_EX     = 1'b0;
    bubble_EX    = 1'b0;
    unique case (1'b1)
      mem_busy: begin
        stall_IF     = 1'b1;
        stall_ID     = 1'b1;
        stall_EX     = 1'b1;
        stall_dcache = 1'b1;
      end
      take_br: begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end
      take_lu: begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        bubble_EX = 1'b1;
      end
      default: ;
    endcase
  end

  // Dcache-wait FSM with registered wait flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      dcache_wait <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            state       <= DWAIT;
            dcache_wait <= 1'b1;
          end
        end
        DWAIT: begin
          if (dcache_ready) begin
            state       <= RUN;
            dcache_wait <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          dcache_wait <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_dc_miss (
    .clk  (clk),
    .rstn (rstn),
    .inc  (miss),
    .clr  (cnt_clr),
    .cnt  (cnt_dc_miss)
  );

  sat_counter #(.W(CNT_W)) u_cnt_dc_stall (
    .clk  (clk),
    .rstn (rstn),
    .inc  (mem_busy),
    .clr  (cnt_clr),
    .cnt  (cnt_dc_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_lu_stall (
    .clk  (clk),
    .rstn (rstn),
    .inc  (take_lu),
    .clr  (cnt_clr),
    .cnt  (cnt_lu_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk  (clk),
    .rstn (rstn),
    .inc  (take_br),
    .clr  (cnt_clr),
    .cnt  (cnt_flush)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed
// scenarios plus randomized run against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam longint MAXC = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rstn;
  logic ID_valid_a, ID_valid_b;
  logic [4:0] ID_rj_a, ID_rk_a, ID_rj_b, ID_rk_b;
  logic EX_rf_we_a, EX_rf_we_b;
  logic [4:0] EX_rf_waddr_a, EX_rf_waddr_b;
  logic [2:0] EX_mem_type_a, EX_mem_type_b;
  logic EX_br_a, EX_br_b;
  logic [2:0] MEM_mem_type_a, MEM_mem_type_b;
  logic dcache_ready, cnt_clr;
  logic stall_IF, stall_ID, stall_EX, stall_dcache;
  logic flush_ID, flush_EX, bubble_EX, dcache_wait;
  logic [31:0] cnt_dc_miss, cnt_dc_stall;
  logic [31:0] cnt_lu_stall, cnt_flush;
  logic s_IF, s_ID, s_EX, s_DC, s_fID, s_fEX, s_bub;
  logic s_wait;
  logic [3:0] s_miss, s_dcs, s_lus, s_fl;

  int checks = 0;
  int errors = 0;

  longint m_cnt [4];
  bit     m_wait;

  logic e_busy, e_lu, e_br, e_brt, e_lut;
  logic [6:0] e_ctl;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .ID_valid_a(ID_valid_a), .ID_valid_b(ID_valid_b),
    .ID_rj_a(ID_rj_a), .ID_rk_a(ID_rk_a),
    .ID_rj_b(ID_rj_b), .ID_rk_b(ID_rk_b),
    .EX_rf_we_a(EX_rf_we_a), .EX_rf_we_b(EX_rf_we_b),
    .EX_rf_waddr_a(EX_rf_waddr_a),
    .EX_rf_waddr_b(EX_rf_waddr_b),
    .EX_mem_type_a(EX_mem_type_a),
    .EX_mem_type_b(EX_mem_type_b),
    .EX_br_a(EX_br_a), .EX_br_b(EX_br_b),
    .MEM_mem_type_a(MEM_mem_type_a),
    .MEM_mem_type_b(MEM_mem_type_b),
    .dcache_ready(dcache_ready), .cnt_clr(cnt_clr),
    .stall_IF(stall_IF), .stall_ID(stall_ID),
    .stall_EX(stall_EX), .stall_dcache(stall_dcache),
    .flush_ID(flush_ID), .flush_EX(flush_EX),
    .bubble_EX(bubble_EX), .dcache_wait(dcache_wait),
    .cnt_dc_miss(cnt_dc_miss), .cnt_dc_stall(cnt_dc_stall),
    .cnt_lu_stall(cnt_lu_stall), .cnt_flush(cnt_flush)
  );

  // Narrow-counter instance exercises saturation quickly.
  pipeline_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rstn(rstn),
    .ID_valid_a(ID_valid_a), .ID_valid_b(ID_valid_b),
    .ID_rj_a(ID_rj_a), .ID_rk_a(ID_rk_a),
    .ID_rj_b(ID_rj_b), .ID_rk_b(ID_rk_b),
    .EX_rf_we_a(EX_rf_we_a), .EX_rf_we_b(EX_rf_we_b),
    .EX_rf_waddr_a(EX_rf_waddr_a),
    .EX_rf_waddr_b(EX_rf_waddr_b),
    .EX_mem_type_a(EX_mem_type_a),
    .EX_mem_type_b(EX_mem_type_b),
    .EX_br_a(EX_br_a), .EX_br_b(EX_br_b),
    .MEM_mem_type_a(MEM_mem_type_a),
    .MEM_mem_type_b(MEM_mem_type_b),
    .dcache_ready(dcache_ready), .cnt_clr(cnt_clr),
    .stall_IF(s_IF), .stall_ID(s_ID),
    .stall_EX(s_EX), .stall_dcache(s_DC),
    .flush_ID(s_fID), .flush_EX(s_fEX),
    .bubble_EX(s_bub), .dcache_wait(s_wait),
    .cnt_dc_miss(s_miss), .cnt_dc_stall(s_dcs),
    .cnt_lu_stall(s_lus), .cnt_flush(s_fl)
  );

  // Reference: hazard rules evaluated over lane/source tables.
  always_comb begin
    logic [4:0] wa [2];
    logic       ld [2];
    logic [4:0] src [4];
    logic       sv [4];
    wa[0] = EX_rf_waddr_a;
    wa[1] = EX_rf_waddr_b;
    ld[0] = EX_rf_we_a && EX_mem_type_a[2];
    ld[1] = EX_rf_we_b && EX_mem_type_b[2];
    src[0] = ID_rj_a; src[1] = ID_rk_a;
    src[2] = ID_rj_b; src[3] = ID_rk_b;
    sv[0] = ID_valid_a; sv[1] = ID_valid_a;
    sv[2] = ID_valid_b; sv[3] = ID_valid_b;
    e_lu = 1'b0;
    for (int x = 0; x < 2; x++)
      for (int s = 0; s < 4; s++)
        if (ld[x] && wa[x] != 0 && sv[s] && src[s] == wa[x])
          e_lu = 1'b1;
    e_busy = (MEM_mem_type_a != 0 || MEM_mem_type_b != 0)
             && !dcache_ready;
    e_br  = EX_br_a || EX_br_b;
    e_brt = !e_busy && e_br;
    e_lut = !e_busy && !e_br && e_lu;
    if (e_busy)     e_ctl = 7'b1111000;
    else if (e_brt) e_ctl = 7'b0000110;
    else if (e_lut) e_ctl = 7'b1100001;
    else            e_ctl = 7'b0000000;
  end

  function automatic logic [6:0] ctl();
    return {stall_IF, stall_ID, stall_EX, stall_dcache,
            flush_ID, flush_EX, bubble_EX};
  endfunction

  function automatic logic [3:0] sat4(input longint v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  // Advance one clock and step the reference model.
  task automatic tick();
    @(posedge clk);
    if (!rstn) begin
      m_wait = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
        if (e_busy && !m_wait && m_cnt[0] < MAXC) m_cnt[0]++;
        if (e_busy && m_cnt[1] < MAXC) m_cnt[1]++;
        if (e_lut && m_cnt[2] < MAXC) m_cnt[2]++;
        if (e_brt && m_cnt[3] < MAXC) m_cnt[3]++;
      end
      if (!m_wait && e_busy) m_wait = 1;
      else if (m_wait && dcache_ready) m_wait = 0;
    end
    #1;
  endtask

  task automatic idle();
    rstn = 1; cnt_clr = 0; dcache_ready = 0;
    ID_valid_a = 0; ID_valid_b = 0;
    ID_rj_a = 0; ID_rk_a = 0; ID_rj_b = 0; ID_rk_b = 0;
    EX_rf_we_a = 0; EX_rf_we_b = 0;
    EX_rf_waddr_a = 0; EX_rf_waddr_b = 0;
    EX_mem_type_a = 0; EX_mem_type_b = 0;
    EX_br_a = 0; EX_br_b = 0;
    MEM_mem_type_a = 0; MEM_mem_type_b = 0;
  endtask

  task automatic clear();
    cnt_clr = 1; tick(); cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle(); rstn = 0;
    tick(); tick();
    rstn = 1; #1;
    checks++;
    if (dcache_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait got %b want 0", dcache_wait);
    end
    checks++;
    if ({cnt_dc_miss, cnt_dc_stall, cnt_lu_stall, cnt_flush}
        !== 128'd0) begin
      errors++;
      $display("FAIL reset_cnt got %h %h %h %h want 0",
               cnt_dc_miss, cnt_dc_stall, cnt_lu_stall, cnt_flush);
    end
    checks++;
    if (ctl() !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000000", ctl());
    end
  endtask

  task automatic test_load_use();
    idle(); clear();
    EX_rf_we_a = 1; EX_mem_type_a = 3'b110;
    EX_rf_waddr_a = 5; ID_valid_b = 1; ID_rk_b = 5;
    #1;
    checks++;
    if (ctl() !== 7'b1100001) begin
      errors++;
      $display("FAIL lu_ctl got %b want 1100001", ctl());
    end
    tick();
    checks++;
    if (cnt_lu_stall !== 32'd1) begin
      errors++;
      $display("FAIL lu_cnt got %0d want 1", cnt_lu_stall);
    end
    EX_rf_waddr_a = 0; ID_rk_b = 0; #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++;
      $display("FAIL lu_r0 got %b want 0000000", ctl());
    end
    EX_rf_waddr_a = 5; ID_rk_b = 5;
    EX_mem_type_a = 3'b001; #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++;
      $display("FAIL lu_store got %b want 0000000", ctl());
    end
    EX_mem_type_a = 3'b110; ID_valid_b = 0; #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++;
      $display("FAIL lu_invalid got %b want 0000000", ctl());
    end
    idle();
  endtask

  task automatic test_dcache_miss();
    idle(); clear();
    MEM_mem_type_a = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl() !== 7'b1111000 || dcache_wait !== (i > 0)) begin
        errors++;
        $display("FAIL miss_c%0d got %b/%b want 1111000/%b",
                 i, ctl(), dcache_wait, i > 0);
      end
      tick();
    end
    dcache_ready = 1; #1;
    checks++;
    if (ctl() !== 7'b0 || dcache_wait !== 1'b1) begin
      errors++;
      $display("FAIL miss_done got %b/%b want 0000000/1",
               ctl(), dcache_wait);
    end
    tick(); idle(); #1;
    checks++;
    if (dcache_wait !== 1'b0 || cnt_dc_miss !== 32'd1
        || cnt_dc_stall !== 32'd3) begin
      errors++;
      $display("FAIL miss_cnt got w%b m%0d s%0d want w0 m1 s3",
               dcache_wait, cnt_dc_miss, cnt_dc_stall);
    end
  endtask

  task automatic test_branch_priority();
    idle(); clear();
    EX_rf_we_a = 1; EX_mem_type_a = 3'b100;
    EX_rf_waddr_a = 7; ID_valid_a = 1; ID_rj_a = 7;
    EX_br_b = 1; #1;
    checks++;
    if (ctl() !== 7'b0000110) begin
      errors++;
      $display("FAIL br_lu got %b want 0000110", ctl());
    end
    tick();
    checks++;
    if (cnt_flush !== 32'd1 || cnt_lu_stall !== 32'd0) begin
      errors++;
      $display("FAIL br_cnt got f%0d l%0d want f1 l0",
               cnt_flush, cnt_lu_stall);
    end
    idle();
  endtask

  task automatic test_branch_in_stall();
    idle(); clear();
    EX_br_a = 1; MEM_mem_type_b = 3'b100;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl() !== 7'b1111000) begin
        errors++;
        $display("FAIL brst_c%0d got %b want 1111000", i, ctl());
      end
      tick();
    end
    dcache_ready = 1; #1;
    checks++;
    if (ctl() !== 7'b0000110) begin
      errors++;
      $display("FAIL brst_fire got %b want 0000110", ctl());
    end
    tick(); idle();
    checks++;
    if (cnt_flush !== 32'd1) begin
      errors++;
      $display("FAIL brst_cnt got %0d want 1", cnt_flush);
    end
  endtask

  task automatic test_back_to_back();
    idle(); clear();
    MEM_mem_type_a = 3'b100; tick();
    dcache_ready = 1; tick();
    dcache_ready = 0; MEM_mem_type_a = 3'b101; tick();
    checks++;
    if (dcache_wait !== 1'b1 || cnt_dc_miss !== 32'd2) begin
      errors++;
      $display("FAIL b2b got w%b m%0d want w1 m2",
               dcache_wait, cnt_dc_miss);
    end
    dcache_ready = 1; tick(); idle();
  endtask

  task automatic test_ready_same_cycle();
    idle(); clear();
    MEM_mem_type_b = 3'b101; dcache_ready = 1; #1;
    checks++;
    if (ctl() !== 7'b0) begin
      errors++;
      $display("FAIL hit_ctl got %b want 0000000", ctl());
    end
    tick();
    checks++;
    if (dcache_wait !== 1'b0 || cnt_dc_miss !== 32'd0
        || cnt_dc_stall !== 32'd0) begin
      errors++;
      $display("FAIL hit_cnt got w%b m%0d s%0d want 0 0 0",
               dcache_wait, cnt_dc_miss, cnt_dc_stall);
    end
    idle();
  endtask

  task automatic test_reset_mid_miss();
    idle(); clear();
    MEM_mem_type_a = 3'b100; tick();
    rstn = 0; #1;
    checks++;
    if (ctl() !== 7'b1111000 || dcache_wait !== 1'b1) begin
      errors++;
      $display("FAIL rstmiss_pre got %b/%b want 1111000/1",
               ctl(), dcache_wait);
    end
    tick();
    checks++;
    if (dcache_wait !== 1'b0 || cnt_dc_miss !== 32'd0) begin
      errors++;
      $display("FAIL rstmiss_rst got w%b m%0d want w0 m0",
               dcache_wait, cnt_dc_miss);
    end
    rstn = 1; tick();
    checks++;
    if (dcache_wait !== 1'b1 || cnt_dc_miss !== 32'd1) begin
      errors++;
      $display("FAIL rstmiss_re got w%b m%0d want w1 m1",
               dcache_wait, cnt_dc_miss);
    end
    dcache_ready = 1; tick(); idle();
  endtask

  task automatic test_clr();
    idle(); clear();
    MEM_mem_type_a = 3'b100; tick();
    cnt_clr = 1; tick(); cnt_clr = 0;
    checks++;
    if (dcache_wait !== 1'b1 || cnt_dc_miss !== 32'd0
        || cnt_dc_stall !== 32'd0) begin
      errors++;
      $display("FAIL clr got w%b m%0d s%0d want w1 m0 s0",
               dcache_wait, cnt_dc_miss, cnt_dc_stall);
    end
    dcache_ready = 1; tick(); idle();
  endtask

  task automatic test_saturation();
    idle(); clear();
    MEM_mem_type_a = 3'b100;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (s_dcs !== 4'hF || s_miss !== 4'd1
        || cnt_dc_stall !== 32'd20) begin
      errors++;
      $display("FAIL sat got s%h m%h w%0d want sF m1 w20",
               s_dcs, s_miss, cnt_dc_stall);
    end
    cnt_clr = 1; tick(); cnt_clr = 0;
    checks++;
    if (s_dcs !== 4'h0) begin
      errors++;
      $display("FAIL sat_clr got %h want 0", s_dcs);
    end
    dcache_ready = 1; tick(); idle();
  endtask

  task automatic test_random();
    idle(); clear();
    for (int n = 0; n < 600; n++) begin
      rstn = ($urandom_range(59) != 0);
      cnt_clr = ($urandom_range(49) == 0);
      ID_valid_a = $urandom_range(1);
      ID_valid_b = $urandom_range(1);
      ID_rj_a = 5'($urandom_range(3));
      ID_rk_a = 5'($urandom_range(3));
      ID_rj_b = 5'($urandom_range(3));
      ID_rk_b = 5'($urandom_range(3));
      EX_rf_we_a = $urandom_range(1);
      EX_rf_we_b = $urandom_range(1);
      EX_rf_waddr_a = 5'($urandom_range(3));
      EX_rf_waddr_b = 5'($urandom_range(3));
      EX_mem_type_a = 3'($urandom_range(7));
      EX_mem_type_b = 3'($urandom_range(7));
      EX_br_a = ($urandom_range(7) == 0);
      EX_br_b = ($urandom_range(7) == 0);
      MEM_mem_type_a = ($urandom_range(2) == 0)
                       ? 3'($urandom_range(7)) : 3'b000;
      MEM_mem_type_b = ($urandom_range(3) == 0)
                       ? 3'($urandom_range(7)) : 3'b000;
      dcache_ready = ($urandom_range(2) == 0);
      #1;
      checks++;
      if (ctl() !== e_ctl) begin
        errors++;
        $display("FAIL rnd_ctl n%0d got %b want %b",
                 n, ctl(), e_ctl);
      end
      tick();
      checks++;
      if (dcache_wait !== m_wait
          || cnt_dc_miss !== m_cnt[0][31:0]
          || cnt_dc_stall !== m_cnt[1][31:0]
          || cnt_lu_stall !== m_cnt[2][31:0]
          || cnt_flush !== m_cnt[3][31:0]) begin
        errors++;
        $display("FAIL rnd_reg n%0d got %b %0d %0d %0d %0d want %b %0d %0d %0d %0d",
                 n, dcache_wait, cnt_dc_miss, cnt_dc_stall,
                 cnt_lu_stall, cnt_flush, m_wait, m_cnt[0],
                 m_cnt[1], m_cnt[2], m_cnt[3]);
      end
      checks++;
      if ({s_miss, s_dcs, s_lus, s_fl} !==
          {sat4(m_cnt[0]), sat4(m_cnt[1]),
           sat4(m_cnt[2]), sat4(m_cnt[3])}) begin
        errors++;
        $display("FAIL rnd_sat n%0d got %h %h %h %h",
                 n, s_miss, s_dcs, s_lus, s_fl);
      end
    end
    idle();
  endtask

  initial begin
    m_wait = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_branch_priority();
    test_branch_in_stall();
    test_back_to_back();
    test_ready_same_cycle();
    test_reset_mid_miss();
    test_clr();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the dual-issue (lane A / lane B) in-order pipeline. It watches ID-stage sources, EX-stage destinations and load types, EX branch-correction flags and MEM-stage dcache handshakes. It produces per-stage stall, flush and bubble controls for the IF/ID, ID/EX and EX/MEM pipeline registers; `stall_dcache` feeds the EX→MEM register directly. A two-state dcache-wait FSM and saturating performance counters provide stall and flush statistics.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: pipeline clock.
- `rstn` in 1: reset, synchronous, active-low.
- `ID_valid_a`, `ID_valid_b` in 1: lane holds a valid instruction in ID.
- `ID_rj_a`, `ID_rk_a`, `ID_rj_b`, `ID_rk_b` in 5: ID source register addresses; r0 never hazards.
- `EX_rf_we_a`, `EX_rf_we_b` in 1: EX lane register write enable.
- `EX_rf_waddr_a`, `EX_rf_waddr_b` in 5: EX lane destination register.
- `EX_mem_type_a`, `EX_mem_type_b` in 3: EX access type; 000 = none, bit2 = 1 means load.
- `EX_br_a`, `EX_br_b` in 1: EX lane requires branch-prediction correction.
- `MEM_mem_type_a`, `MEM_mem_type_b` in 3: MEM access type, same encoding.
- `dcache_ready` in 1: dcache completes the MEM access this cycle.
- `cnt_clr` in 1: synchronous clear of all counters.
- `stall_IF`, `stall_ID`, `stall_EX`, `stall_dcache` out 1: hold PC, IF/ID, ID/EX, EX/MEM respectively.
- `flush_ID`, `flush_EX` out 1: clear IF/ID and ID/EX registers (wrong path).
- `bubble_EX` out 1: load ID/EX with a NOP while ID holds.
- `dcache_wait` out 1: FSM in DWAIT.
- `cnt_dc_miss`, `cnt_dc_stall`, `cnt_lu_stall`, `cnt_flush` out `CNT_W`: event and cycle counters.

## Operation
- `mem_busy` = (`MEM_mem_type_a` != 0 or `MEM_mem_type_b` != 0) and not `dcache_ready`.
- `lu_hit`: some EX lane X has `EX_rf_we_X`, `EX_mem_type_X[2]` set and `EX_rf_waddr_X` != 0. Its `EX_rf_waddr_X` equals `ID_rj` or `ID_rk` of some lane Y with `ID_valid_Y`. All 8 lane/source combinations are checked.
- `br` = `EX_br_a` or `EX_br_b`.
- Priority is strict: dcache > branch > load-use.
  - `mem_busy`: all four stall outputs = 1. Flush and bubble outputs = 0.
  - Else if `br`: `flush_ID` = `flush_EX` = 1. Stalls and bubble = 0. Lane-B squash on `EX_br_a` is performed by the EX→MEM register itself, not here.
  - Else if `lu_hit`: `stall_IF` = `stall_ID` = 1 and `bubble_EX` = 1. `stall_EX` = `stall_dcache` = 0.
  - Else: all control outputs 0.
- FSM states:
  - RUN → DWAIT when `mem_busy`.
  - DWAIT → RUN on the cycle `dcache_ready` = 1.
  - DWAIT holds otherwise.
  - `dcache_wait` = (state == DWAIT).
- Counters, updated at the clock edge and saturating at all-ones:
  - `cnt_dc_miss` +1 on the RUN→DWAIT transition.
  - `cnt_dc_stall` +1 each cycle `mem_busy`.
  - `cnt_lu_stall` +1 each cycle the load-use branch of the priority is taken.
  - `cnt_flush` +1 each cycle the branch arm is taken.
- A branch arriving during a dcache stall is not lost. EX is frozen, so `EX_br` persists and the flush fires on the first cycle `mem_busy` = 0. That cycle counts once in `cnt_flush`.
- `cnt_clr` zeroes all counters and has priority over increments. It does not affect the FSM.

## Timing
- All stall, flush and bubble outputs are combinational from current inputs, with zero-cycle latency.
- FSM and counters are registered, with one-cycle update.
- Reset (rstn = 0 at a clock edge):
  - state = RUN, all counters = 0.
  - During reset, combinational outputs still follow inputs. `dcache_wait` reads 0 from the edge after reset.
- Reset mid-miss returns the FSM to RUN. If MEM is still busy, it re-enters DWAIT and counts a new miss.
- A miss with `dcache_ready` = 1 in the same cycle as the MEM access produces no stall and no FSM transition.
- Back-to-back misses (ready, then a new MEM op that is not ready):
  - DWAIT → RUN → DWAIT.
  - `cnt_dc_miss` +2 in total.
- Counter saturation: a counter at all-ones stays at all-ones.

## Structure
- The shared pipeline package holds:
  - `MEM_NONE` = 3'b000 and `MEM_LOAD_BIT` = 2.
  - The `hz_state_t` enum {RUN, DWAIT}.
- One natural sub-module: `sat_counter` (width, inc, clr, synchronous active-low reset), instantiated four times.

## Test plan
- EX lane A: load r5 (`EX_mem_type_a` = 3'b110, we = 1). ID lane B: `ID_rk_b` = 5. Required response for exactly that cycle:
  - `stall_IF` = `stall_ID` = `bubble_EX` = 1, `stall_EX` = 0.
  - `cnt_lu_stall` = 1 afterwards.
- Same as above but `EX_rf_waddr_a` = 0 → no stall. Same with a store (3'b001) → no stall.
- MEM load with `dcache_ready` low for 3 cycles, then high:
  - All four stalls high for 3 cycles.
  - `dcache_wait` high for 3 cycles starting one cycle later.
  - `cnt_dc_miss` = 1, `cnt_dc_stall` = 3.
- `EX_br_b` = 1 together with `lu_hit`:
  - `flush_ID` = `flush_EX` = 1, `bubble_EX` = 0.
  - `cnt_flush` +1, `cnt_lu_stall` unchanged.
- `EX_br_a` held during a 2-cycle dcache stall:
  - No flush for 2 cycles, then the flush on cycle 3.
  - `cnt_flush` = 1.
- Preload a counter to all-ones via a force/backdoor, then increment → it stays at 0xFFFFFFFF. `cnt_clr` → 0. `rstn` low during DWAIT → state RUN at the next edge.
